// File: rtl/draw_sequencer_if.sv
// Request handshake plus per-pixel datapath control bundle between the game FSM,
// the draw sequencer and the drawing datapath.
interface draw_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_kind;
    logic [6:0] req_mem;
    logic [4:0] req_slot;
    logic [1:0] req_row;

    logic [6:0] memorySel;
    logic [4:0] xInitSel;
    logic [1:0] yInitSel;
    logic [1:0] xySel;
    logic       xInitLoad;
    logic       yInitLoad;
    logic       xInitReset;
    logic       yInitReset;
    logic       xReset;
    logic       yReset;
    logic       xLoad;
    logic       yLoad;
    logic       xCountUp;
    logic       yCountUp;
    logic       addressScreenCounterReset;
    logic       screenCountLoad;
    logic       addressSpriteCounterReset;
    logic       spriteCountLoad;
    logic       black;
    logic       plot;
    logic       busy;
    logic       done;
    logic       err;

    // Requester side (game FSM / datapath consumer).
    modport master (
        output req_valid, req_kind, req_mem, req_slot, req_row,
        input  req_ready, memorySel, xInitSel, yInitSel, xySel,
        input  xInitLoad, yInitLoad, xInitReset, yInitReset, xReset, yReset,
        input  xLoad, yLoad, xCountUp, yCountUp,
        input  addressScreenCounterReset, screenCountLoad,
        input  addressSpriteCounterReset, spriteCountLoad,
        input  black, plot, busy, done, err
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_kind, req_mem, req_slot, req_row,
        output req_ready, memorySel, xInitSel, yInitSel, xySel,
        output xInitLoad, yInitLoad, xInitReset, yInitReset, xReset, yReset,
        output xLoad, yLoad, xCountUp, yCountUp,
        output addressScreenCounterReset, screenCountLoad,
        output addressSpriteCounterReset, spriteCountLoad,
        output black, plot, busy, done, err
    );
endinterface

// File: rtl/draw_sequencer.sv
// Draw sequencer: walks the drawing datapath pixel by pixel for one SCREEN, SPRITE or CLEAR request.
// Latency: plots start 3 cycles after accept, done N+3 cycles after accept; requests are not queued.
module draw_sequencer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 40
) (
    input logic             clk,
    input logic             reset,
    draw_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRIME,
        S_DRAW,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        K_SCREEN  = 2'd0,
        K_SPRITE  = 2'd1,
        K_CLEAR   = 2'd2,
        K_ILLEGAL = 2'd3
    } kind_t;

    typedef struct packed {
        logic ready;
        logic busy;
        logic done;
        logic err;
        logic init_load;
        logic init_reset;
        logic x_reset;
        logic y_reset;
        logic xy_load;
        logic x_up;
        logic y_up;
        logic scr_rst;
        logic scr_inc;
        logic spr_rst;
        logic spr_inc;
        logic black;
        logic plot;
    } ctl_t;

    localparam logic [7:0] SCR_W_M1 = 8'(SCREEN_W - 1);
    localparam logic [6:0] SCR_H_M1 = 7'(SCREEN_H - 1);
    localparam logic [7:0] SPR_W_M1 = 8'(SPRITE_W - 1);
    localparam logic [6:0] SPR_H_M1 = 7'(SPRITE_H - 1);

    state_t     state;
    kind_t      kind_q;
    ctl_t       ctl;
    logic [6:0] mem_q;
    logic [4:0] slot_q;
    logic [1:0] row_sel_q;
    logic [7:0] col;
    logic [6:0] row;
    logic [7:0] w_m1;
    logic [6:0] h_m1;
    logic [7:0] col_nxt;
    logic [6:0] row_nxt;
    kind_t      req_kind;

    assign req_kind = kind_t'(bus.req_kind);

    function automatic ctl_t ctl_idle();
        ctl_t o;
        o       = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic ctl_t ctl_reset();
        ctl_t o;
        o            = ctl_idle();
        o.init_reset = 1'b1;
        o.x_reset    = 1'b1;
        o.y_reset    = 1'b1;
        o.scr_rst    = 1'b1;
        o.spr_rst    = 1'b1;
        return o;
    endfunction

    function automatic ctl_t ctl_load(input kind_t k);
        ctl_t o;
        o           = '0;
        o.busy      = 1'b1;
        o.init_load = 1'b1;
        o.x_reset   = 1'b1;
        o.y_reset   = 1'b1;
        o.spr_rst   = (k == K_SPRITE);
        o.scr_rst   = (k != K_SPRITE);
        return o;
    endfunction

    // ROM is registered, so its address is advanced one cycle ahead of the first plot.
    function automatic ctl_t ctl_prime(input kind_t k);
        ctl_t o;
        o         = '0;
        o.busy    = 1'b1;
        o.spr_inc = (k == K_SPRITE);
        o.scr_inc = (k != K_SPRITE);
        return o;
    endfunction

    function automatic ctl_t ctl_pixel(input kind_t k, input logic [7:0] c, input logic [6:0] r,
                                       input logic [7:0] wm1, input logic [6:0] hm1);
        ctl_t o;
        logic last;
        o         = '0;
        last      = (c == wm1) && (r == hm1);
        o.busy    = 1'b1;
        o.plot    = 1'b1;
        o.xy_load = 1'b1;
        o.black   = (k == K_CLEAR);
        if (c < wm1) begin
            o.x_up = 1'b1;
        end else begin
            o.x_reset = 1'b1;
            o.y_up    = (r < hm1);
        end
        o.spr_inc = !last && (k == K_SPRITE);
        o.scr_inc = !last && (k != K_SPRITE);
        return o;
    endfunction

    function automatic ctl_t ctl_finish(input logic e);
        ctl_t o;
        o      = '0;
        o.busy = 1'b1;
        o.done = 1'b1;
        o.err  = e;
        return o;
    endfunction

    always_comb begin
        col_nxt = col + 8'd1;
        row_nxt = row;
        if (col >= w_m1) begin
            col_nxt = '0;
            row_nxt = row + 7'd1;
        end
    end

    // Outputs are registered: each transition loads the control word of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            kind_q    <= K_SCREEN;
            mem_q     <= '0;
            slot_q    <= '0;
            row_sel_q <= '0;
            col       <= '0;
            row       <= '0;
            w_m1      <= '0;
            h_m1      <= '0;
            ctl       <= ctl_reset();
        end else begin
            case (state)
                S_IDLE: begin
                    ctl <= ctl_idle();
                    if (bus.req_valid) begin
                        kind_q    <= req_kind;
                        mem_q     <= bus.req_mem;
                        slot_q    <= bus.req_slot;
                        row_sel_q <= bus.req_row;
                        w_m1      <= (req_kind == K_SPRITE) ? SPR_W_M1 : SCR_W_M1;
                        h_m1      <= (req_kind == K_SPRITE) ? SPR_H_M1 : SCR_H_M1;
                        if (req_kind == K_ILLEGAL) begin
                            state <= S_FINISH;
                            ctl   <= ctl_finish(1'b1);
                        end else begin
                            state <= S_LOAD;
                            ctl   <= ctl_load(req_kind);
                        end
                    end
                end
                S_LOAD: begin
                    col   <= '0;
                    row   <= '0;
                    state <= S_PRIME;
                    ctl   <= ctl_prime(kind_q);
                end
                S_PRIME: begin
                    col   <= '0;
                    row   <= '0;
                    state <= S_DRAW;
                    ctl   <= ctl_pixel(kind_q, 8'd0, 7'd0, w_m1, h_m1);
                end
                S_DRAW: begin
                    if (col == w_m1 && row == h_m1) begin
                        state <= S_FINISH;
                        ctl   <= ctl_finish(1'b0);
                    end else begin
                        col <= col_nxt;
                        row <= row_nxt;
                        ctl <= ctl_pixel(kind_q, col_nxt, row_nxt, w_m1, h_m1);
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    ctl   <= ctl_idle();
                end
                default: begin
                    state <= S_IDLE;
                    ctl   <= ctl_idle();
                end
            endcase
        end
    end

    assign bus.req_ready                 = ctl.ready;
    assign bus.busy                      = ctl.busy;
    assign bus.done                      = ctl.done;
    assign bus.err                       = ctl.err;
    assign bus.memorySel                 = mem_q;
    assign bus.xInitSel                  = slot_q;
    assign bus.yInitSel                  = row_sel_q;
    assign bus.xySel                     = {1'b0, kind_q == K_SPRITE};
    assign bus.xInitLoad                 = ctl.init_load;
    assign bus.yInitLoad                 = ctl.init_load;
    assign bus.xInitReset                = ctl.init_reset;
    assign bus.yInitReset                = ctl.init_reset;
    assign bus.xReset                    = ctl.x_reset;
    assign bus.yReset                    = ctl.y_reset;
    assign bus.xLoad                     = ctl.xy_load;
    assign bus.yLoad                     = ctl.xy_load;
    assign bus.xCountUp                  = ctl.x_up;
    assign bus.yCountUp                  = ctl.y_up;
    assign bus.addressScreenCounterReset = ctl.scr_rst;
    assign bus.screenCountLoad           = ctl.scr_inc;
    assign bus.addressSpriteCounterReset = ctl.spr_rst;
    assign bus.spriteCountLoad           = ctl.spr_inc;
    assign bus.black                     = ctl.black;
    assign bus.plot                      = ctl.plot;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: reset state, SCREEN/SPRITE/CLEAR timing and counts,
// mid-draw reset abort, illegal kind, and held request during a draw.
module tb_draw_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    draw_sequencer_if bus();

    draw_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int plots, first_plot, last_plot, yups, xrst_plot;
        int blacks, black_off, done_at, err_at, err_cnt;
        int overlap, ready_busy, load_at, ready_after;
    } res_t;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycle k of the result is k cycles after the accept cycle T.
    task automatic run_req(input logic [1:0] kind, input logic [6:0] mem, input logic [4:0] slot,
                           input logic [1:0] rsel, input bit hold, output res_t r);
        bit seen_done;
        r = '{default: 0};
        r.first_plot = -1;
        r.last_plot  = -1;
        r.done_at    = -1;
        r.err_at     = -1;
        r.load_at    = -1;
        seen_done    = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_kind  = kind;
        bus.req_mem   = mem;
        bus.req_slot  = slot;
        bus.req_row   = rsel;
        @(posedge clk);
        for (int k = 1; k <= 20000 && !seen_done; k++) begin
            @(negedge clk);
            if (!hold) bus.req_valid = 1'b0;
            if (bus.plot) begin
                r.plots++;
                if (r.first_plot < 0) r.first_plot = k;
                r.last_plot = k;
            end
            if (bus.yCountUp) r.yups++;
            if (bus.xReset && bus.plot) r.xrst_plot++;
            if (bus.black) r.blacks++;
            if (bus.black && !bus.plot) r.black_off++;
            if ((bus.xCountUp && bus.xReset) || (bus.screenCountLoad && bus.spriteCountLoad)) r.overlap++;
            if (bus.req_ready) r.ready_busy++;
            if (bus.xInitLoad && bus.yInitLoad && r.load_at < 0) r.load_at = k;
            if (bus.err) begin
                r.err_cnt++;
                if (r.err_at < 0) r.err_at = k;
            end
            if (bus.done) begin
                r.done_at = k;
                seen_done = 1'b1;
            end
        end
        @(negedge clk);
        r.ready_after = int'(bus.req_ready);
    endtask

    initial begin
        res_t r;
        int   n;
        int   cnt;
        bit   found;

        bus.req_valid = 1'b0;
        bus.req_kind  = 2'd0;
        bus.req_mem   = 7'd0;
        bus.req_slot  = 5'd0;
        bus.req_row   = 2'd0;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_xInitReset", int'(bus.xInitReset), 1);
        check("rst_addrSprReset", int'(bus.addressSpriteCounterReset), 1);
        check("rst_ready", int'(bus.req_ready), 1);
        check("rst_plot", int'(bus.plot), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", int'(bus.req_ready), 1);
        check("idle_plot", int'(bus.plot), 0);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_done", int'(bus.done), 0);
        check("idle_memsel", int'(bus.memorySel), 0);
        check("idle_xinitsel", int'(bus.xInitSel), 0);
        check("idle_yinitsel", int'(bus.yInitSel), 0);
        check("idle_xreset", int'(bus.xReset), 0);

        // SCREEN, mem=5
        run_req(2'd0, 7'd5, 5'd0, 2'd0, 1'b0, r);
        check("scr_memsel", int'(bus.memorySel), 5);
        check("scr_xysel", int'(bus.xySel), 0);
        check("scr_plots", r.plots, 19200);
        check("scr_first_plot", r.first_plot, 3);
        check("scr_last_plot", r.last_plot, 19202);
        check("scr_contiguous", r.last_plot - r.first_plot + 1, 19200);
        check("scr_done_at", r.done_at, 19203);
        check("scr_yups", r.yups, 119);
        check("scr_xrst_plot", r.xrst_plot, 120);
        check("scr_overlap", r.overlap, 0);
        check("scr_err", r.err_cnt, 0);
        check("scr_black", r.blacks, 0);
        check("scr_ready_busy", r.ready_busy, 0);
        check("scr_ready_after", r.ready_after, 1);

        // SPRITE, slot=3 row=2
        run_req(2'd1, 7'd9, 5'd3, 2'd2, 1'b0, r);
        check("spr_xinitsel", int'(bus.xInitSel), 3);
        check("spr_yinitsel", int'(bus.yInitSel), 2);
        check("spr_xysel", int'(bus.xySel), 1);
        check("spr_memsel", int'(bus.memorySel), 9);
        check("spr_load_at", r.load_at, 1);
        check("spr_plots", r.plots, 1600);
        check("spr_first_plot", r.first_plot, 3);
        check("spr_xrst_plot", r.xrst_plot, 40);
        check("spr_yups", r.yups, 39);
        check("spr_done_at", r.done_at, 1603);
        check("spr_overlap", r.overlap, 0);
        check("spr_ready_after", r.ready_after, 1);

        // CLEAR
        run_req(2'd2, 7'd0, 5'd0, 2'd0, 1'b0, r);
        check("clr_plots", r.plots, 19200);
        check("clr_black", r.blacks, 19200);
        check("clr_black_off", r.black_off, 0);
        check("clr_err", r.err_cnt, 0);
        check("clr_done_at", r.done_at, 19203);
        check("clr_xysel", int'(bus.xySel), 0);

        // Reset at the 500th plot of a SCREEN draw
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'd0;
        bus.req_mem   = 7'd4;
        @(posedge clk);
        n = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.plot) n++;
            if (n == 500) break;
        end
        check("abort_plot_reached", n, 500);
        reset = 1'b1;
        @(negedge clk);
        check("abort_plot", int'(bus.plot), 0);
        check("abort_ready", int'(bus.req_ready), 1);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_xreset", int'(bus.xReset), 1);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done || bus.plot) cnt++;
        end
        check("abort_quiet", cnt, 0);
        run_req(2'd1, 7'd6, 5'd1, 2'd1, 1'b0, r);
        check("after_abort_plots", r.plots, 1600);
        check("after_abort_done_at", r.done_at, 1603);

        // Illegal kind
        run_req(2'd3, 7'd11, 5'd7, 2'd1, 1'b0, r);
        check("ill_done_at", r.done_at, 1);
        check("ill_err_at", r.err_at, 1);
        check("ill_err_cnt", r.err_cnt, 1);
        check("ill_plots", r.plots, 0);
        check("ill_memsel", int'(bus.memorySel), 11);
        check("ill_ready_after", r.ready_after, 1);

        // req_valid held through a SPRITE draw
        run_req(2'd1, 7'd2, 5'd1, 2'd0, 1'b1, r);
        check("hold_ready_busy", r.ready_busy, 0);
        check("hold_plots", r.plots, 1600);
        check("hold_done_at", r.done_at, 1603);
        check("hold_ready_back", r.ready_after, 1);
        @(negedge clk);
        check("hold_second_accept", int'(bus.busy), 1);
        bus.req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (bus.done) found = 1'b1;
        end
        check("hold_second_done", int'(found), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
